// File: rtl/rx_iq_scheduler_if.sv
`timescale 1ns/1ps
// rx_iq_scheduler_if
//   Output beat stream from the receiver-chain scheduler towards the packet
//   formatter / FIFO.
//
//   Handshake: a beat transfers on a rising clock edge where out_valid and
//   out_ready are both high. While out_valid is high and out_ready is low,
//   the master holds out_chan, out_data_I, out_data_Q and out_last constant.
//   out_valid never drops without a transfer. out_ready may be driven freely
//   and does not depend on out_valid.
//
//   Signals
//     out_valid   master -> slave   beat valid
//     out_ready   slave  -> master  beat accepted when out_valid is high
//     out_chan    master -> slave   channel index of the beat
//     out_data_I  master -> slave   I sample
//     out_data_Q  master -> slave   Q sample
//     out_last    master -> slave   final beat of a frame
interface rx_iq_scheduler_if #(
  parameter int CW = 2,
  parameter int DW = 24
);
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_chan;
  logic [DW-1:0] out_data_I;
  logic [DW-1:0] out_data_Q;
  logic          out_last;

  modport master (
    output out_valid, out_chan, out_data_I, out_data_Q, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_chan, out_data_I, out_data_Q, out_last,
    output out_ready
  );
endinterface

// File: rtl/rx_iq_scheduler.sv
`timescale 1ns/1ps
// rx_iq_scheduler
//   Shares one downstream sample path between NUM_RX receiver chains. Each
//   strobed I/Q sample is captured into a one-deep holding register per
//   channel. Once every enabled channel holds a fresh sample, one frame is
//   emitted: one beat per enabled channel in ascending channel order, with
//   out_last on the highest enabled channel. Overwriting a sample that was
//   never sent sets a sticky per-channel overrun flag.
//
//   Ports
//     clock, reset_n   system clock, asynchronous active-low reset
//     rx_enable        per-channel enable, sampled only while idle
//     in_strobe        per-channel sample-valid pulse
//     in_data_I/Q      packed samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//     out_if           output beat stream (master side)
//     busy             high while a frame is being sent
//     overrun          sticky per-channel overrun flags
//     clear_overrun    single-cycle pulse, clears all overrun flags
//     dbg_state        current FSM state (0 = IDLE, 1 = SEND)
module rx_iq_scheduler #(
  parameter int NUM_RX     = 4,
  parameter int DATA_WIDTH = 24
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_RX-1:0]            rx_enable,
  input  logic [NUM_RX-1:0]            in_strobe,
  input  logic [NUM_RX*DATA_WIDTH-1:0] in_data_I,
  input  logic [NUM_RX*DATA_WIDTH-1:0] in_data_Q,
  rx_iq_scheduler_if.master            out_if,
  output logic                         busy,
  output logic [NUM_RX-1:0]            overrun,
  input  logic                         clear_overrun,
  output logic                         dbg_state
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(NUM_RX);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [NUM_RX-1:0] en_q;
  logic [NUM_RX-1:0] pending_q;
  logic [DW-1:0]   hold_i_q [NUM_RX];
  logic [DW-1:0]   hold_q_q [NUM_RX];

  logic            valid_q, last_q;
  logic [CW-1:0]   chan_q;
  logic [DW-1:0]   data_i_q, data_q_q;

  logic [CW-1:0]   first_chan, high_chan, next_chan;
  logic            next_found;
  logic            fire, load, frame_done;
  logic [CW-1:0]   load_chan;
  logic [NUM_RX-1:0] ovr_set;

  assign fire = valid_q & out_if.out_ready;

  // Lowest enabled channel, highest enabled channel, and the next enabled
  // channel above the one currently on the output.
  always_comb begin
    first_chan = '0;
    high_chan  = '0;
    next_chan  = '0;
    next_found = 1'b0;
    for (int i = NUM_RX - 1; i >= 0; i--) begin
      if (en_q[i]) begin
        first_chan = CW'(i);
        if (CW'(i) > chan_q) begin
          next_chan  = CW'(i);
          next_found = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_RX; i++) begin
      if (en_q[i]) high_chan = CW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_chan  = first_chan;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((en_q != '0) && ((pending_q & en_q) == en_q)) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fire) begin
          if (next_found) begin
            load      = 1'b1;
            load_chan = next_chan;
          end else begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new strobe on a channel whose previous sample is still unsent is an
  // overrun, unless that old sample is being moved to the output this cycle.
  always_comb begin
    ovr_set = '0;
    for (int k = 0; k < NUM_RX; k++) begin
      ovr_set[k] = in_strobe[k] & en_q[k] & pending_q[k] &
                   ~(load && (load_chan == CW'(k)));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      en_q    <= '0;
      overrun <= '0;
    end else begin
      state_q <= state_d;
      // The enable set is frozen from the edge a frame starts until it ends,
      // so a frame is always built from one consistent set of channels.
      if (state_q == IDLE && !load) en_q <= rx_enable;
      overrun <= (clear_overrun ? '0 : overrun) | ovr_set;
    end
  end

  // Capture takes priority over the load-clear: a strobe in the same cycle
  // as its channel is loaded keeps pending set with the newer sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      for (int k = 0; k < NUM_RX; k++) begin
        hold_i_q[k] <= '0;
        hold_q_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_RX; k++) begin
        if (in_strobe[k] && en_q[k]) begin
          hold_i_q[k]  <= in_data_I[k*DW +: DW];
          hold_q_q[k]  <= in_data_Q[k*DW +: DW];
          pending_q[k] <= 1'b1;
        end else if (load && (load_chan == CW'(k))) begin
          pending_q[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      chan_q   <= '0;
      data_i_q <= '0;
      data_q_q <= '0;
    end else if (load) begin
      valid_q  <= 1'b1;
      chan_q   <= load_chan;
      data_i_q <= hold_i_q[load_chan];
      data_q_q <= hold_q_q[load_chan];
      last_q   <= (load_chan == high_chan);
    end else if (frame_done) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign out_if.out_valid  = valid_q;
  assign out_if.out_chan   = chan_q;
  assign out_if.out_data_I = data_i_q;
  assign out_if.out_data_Q = data_q_q;
  assign out_if.out_last   = last_q;
  assign busy              = (state_q == SEND);
  assign dbg_state         = (state_q == SEND);
endmodule

// File: tb/tb_rx_iq_scheduler.sv
`timescale 1ns/1ps
module tb_rx_iq_scheduler;
  localparam int NR = 4;
  localparam int DW = 24;
  localparam int CW = 2;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [NR-1:0]    rx_enable;
  logic [NR-1:0]    in_strobe;
  logic [NR*DW-1:0] in_data_I;
  logic [NR*DW-1:0] in_data_Q;
  logic             clear_overrun;
  logic             busy;
  logic [NR-1:0]    overrun;
  logic             dbg_state;

  rx_iq_scheduler_if #(.CW(CW), .DW(DW)) bus ();

  rx_iq_scheduler #(.NUM_RX(NR), .DATA_WIDTH(DW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx_enable     (rx_enable),
    .in_strobe     (in_strobe),
    .in_data_I     (in_data_I),
    .in_data_Q     (in_data_Q),
    .out_if        (bus.master),
    .busy          (busy),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .dbg_state     (dbg_state)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  // Channels hold their newest sample; a frame starts once all enabled
  // channels hold one, and is the ascending list of enabled channels.
  logic [NR-1:0] m_pend, m_ovr, m_en, m_en_old, m_set;
  logic [DW-1:0] m_hold_i [NR];
  logic [DW-1:0] m_hold_q [NR];
  logic          m_busy, m_valid, m_last;
  logic [CW-1:0] m_chan;
  logic [DW-1:0] m_i, m_q;
  int            frame_q[$];
  int            m_ld;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = '0; m_ovr = '0; m_en = '0;
      m_busy = 1'b0; m_valid = 1'b0; m_last = 1'b0;
      m_chan = '0; m_i = '0; m_q = '0;
      for (int k = 0; k < NR; k++) begin
        m_hold_i[k] = '0;
        m_hold_q[k] = '0;
      end
      frame_q.delete();
    end else begin
      m_ld     = -1;
      m_en_old = m_en;
      m_set    = '0;
      if (!m_busy) begin
        if (m_en != '0 && (m_pend & m_en) == m_en) begin
          frame_q.delete();
          for (int k = 0; k < NR; k++) if (m_en[k]) frame_q.push_back(k);
          m_ld   = frame_q.pop_front();
          m_busy = 1'b1;
        end else begin
          m_en = rx_enable;
        end
      end else if (m_valid && bus.out_ready) begin
        if (frame_q.size() > 0) m_ld = frame_q.pop_front();
        else begin
          m_valid = 1'b0;
          m_last  = 1'b0;
          m_busy  = 1'b0;
        end
      end
      if (m_ld >= 0) begin
        m_valid = 1'b1;
        m_chan  = CW'(m_ld);
        m_i     = m_hold_i[m_ld];
        m_q     = m_hold_q[m_ld];
        m_last  = (frame_q.size() == 0);
      end
      for (int k = 0; k < NR; k++) begin
        if (in_strobe[k] && m_en_old[k]) begin
          if (m_pend[k] && m_ld != k) m_set[k] = 1'b1;
          m_hold_i[k] = in_data_I[k*DW +: DW];
          m_hold_q[k] = in_data_Q[k*DW +: DW];
          m_pend[k]   = 1'b1;
        end else if (m_ld == k) begin
          m_pend[k] = 1'b0;
        end
      end
      m_ovr = (clear_overrun ? '0 : m_ovr) | m_set;
    end
  end

  // ---------------- scoreboard / compare ----------------
  int            log_cyc[$];
  int            log_chan[$];
  logic [DW-1:0] log_i[$];
  logic [DW-1:0] log_q[$];
  logic          log_last[$];

  logic          p_valid, p_ready, p_last;
  logic [CW-1:0] p_chan;
  logic [DW-1:0] p_i, p_q;

  always @(negedge clock) begin
    if (!reset_n) begin
      p_valid = 1'b0;
    end else begin
      chk("out_valid", bus.out_valid, m_valid);
      chk("busy", busy, m_busy);
      chk("dbg_state", dbg_state, m_busy);
      chk("overrun", overrun, m_ovr);
      chk("out_chan", bus.out_chan, m_chan);
      chk("out_data_I", bus.out_data_I, m_i);
      chk("out_data_Q", bus.out_data_Q, m_q);
      chk("out_last", bus.out_last, m_last);
      if (p_valid && !p_ready)
        chk("stall_hold", {bus.out_valid, bus.out_last, bus.out_chan, bus.out_data_I, bus.out_data_Q},
            {1'b1, p_last, p_chan, p_i, p_q});
      if (bus.out_valid && bus.out_ready) begin
        log_cyc.push_back(cyc);
        log_chan.push_back(int'(bus.out_chan));
        log_i.push_back(bus.out_data_I);
        log_q.push_back(bus.out_data_Q);
        log_last.push_back(bus.out_last);
      end
      p_valid = bus.out_valid;
      p_ready = bus.out_ready;
      p_last  = bus.out_last;
      p_chan  = bus.out_chan;
      p_i     = bus.out_data_I;
      p_q     = bus.out_data_Q;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_sample(input int k, input logic [DW-1:0] iv, input logic [DW-1:0] qv);
    in_data_I[k*DW +: DW] = iv;
    in_data_Q[k*DW +: DW] = qv;
  endtask

  task automatic pulse(input logic [NR-1:0] mask, input logic clr);
    in_strobe     = mask;
    clear_overrun = clr;
    tick(1);
    in_strobe     = '0;
    clear_overrun = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick(1);
      n++;
    end
    chk(name, bus.out_valid, 1'b1);
  endtask

  task automatic clear_log();
    log_cyc.delete(); log_chan.delete(); log_i.delete(); log_q.delete(); log_last.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    rx_enable     = '0;
    in_strobe     = '0;
    in_data_I     = '0;
    in_data_Q     = '0;
    clear_overrun = 1'b0;
    bus.out_ready = 1'b1;
    tick(3);
    chk("reset_valid", bus.out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_overrun", overrun, 4'b0000);
    chk("reset_chan", bus.out_chan, 2'd0);
    chk("reset_last", bus.out_last, 1'b0);
    chk("reset_data_I", bus.out_data_I, 24'h0);
    reset_n = 1'b1;
    tick(2);

    // All four channels, I=k+1, Q=-(k+1)
    rx_enable = 4'hF;
    tick(2);
    for (int k = 0; k < NR; k++) set_sample(k, DW'(k + 1), DW'(0) - DW'(k + 1));
    clear_log();
    t = cyc;
    pulse(4'hF, 1'b0);
    tick(8);
    chk("f1_beats", log_chan.size(), 4);
    if (log_chan.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("f1_chan", log_chan[i], i);
        chk("f1_cycle", log_cyc[i], t + 2 + i);
        chk("f1_I", log_i[i], DW'(i + 1));
        chk("f1_Q", log_q[i], 24'hFFFFFF - 24'(i));
        chk("f1_last", log_last[i], (i == 3));
      end
    end
    chk("f1_idle", busy, 1'b0);

    // Sparse enable 1010
    rx_enable = 4'b1010;
    tick(2);
    for (int k = 0; k < NR; k++) set_sample(k, 24'h000100 + 24'(k), 24'h000200 + 24'(k));
    clear_log();
    pulse(4'hF, 1'b0);
    tick(8);
    chk("f2_beats", log_chan.size(), 2);
    if (log_chan.size() == 2) begin
      chk("f2_chan0", log_chan[0], 1);
      chk("f2_chan1", log_chan[1], 3);
      chk("f2_last0", log_last[0], 1'b0);
      chk("f2_last1", log_last[1], 1'b1);
      chk("f2_I1", log_i[1], 24'h000103);
    end

    // Stall mid-frame, overrun on channel 2, clear coincident with overrun
    rx_enable = 4'hF;
    tick(2);
    bus.out_ready = 1'b0;
    for (int k = 0; k < NR; k++) set_sample(k, 24'h000300 + 24'(k), 24'h000400 + 24'(k));
    clear_log();
    pulse(4'hF, 1'b0);
    wait_valid("f3_valid");
    tick(3);
    set_sample(2, 24'hABCDEF, 24'h123456);
    pulse(4'b0100, 1'b0);
    chk("f3_overrun_set", overrun, 4'b0100);
    set_sample(2, 24'h777777, 24'h888888);
    pulse(4'b0100, 1'b1);
    chk("f3_overrun_set_wins", overrun, 4'b0100);
    tick(12);
    chk("f3_no_beat_in_stall", log_chan.size(), 0);
    bus.out_ready = 1'b1;
    tick(8);
    chk("f3_beats", log_chan.size(), 4);
    if (log_chan.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("f3_chan", log_chan[i], i);
      chk("f3_I0", log_i[0], 24'h000300);
      chk("f3_I2_newest", log_i[2], 24'h777777);
      chk("f3_Q2_newest", log_q[2], 24'h888888);
      chk("f3_last", log_last[3], 1'b1);
    end
    pulse(4'b0000, 1'b1);
    chk("f3_overrun_cleared", overrun, 4'b0000);

    // Reset mid-frame
    bus.out_ready = 1'b0;
    for (int k = 0; k < NR; k++) set_sample(k, 24'h000500 + 24'(k), 24'h000600 + 24'(k));
    pulse(4'hF, 1'b0);
    wait_valid("f4_valid");
    pulse(4'b0010, 1'b0);
    tick(1);
    chk("f4_overrun_pre", overrun, 4'b0010);
    #2 reset_n = 1'b0;
    #1;
    chk("f4_rst_valid", bus.out_valid, 1'b0);
    chk("f4_rst_busy", busy, 1'b0);
    chk("f4_rst_overrun", overrun, 4'b0000);
    tick(2);
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    tick(2);
    for (int k = 0; k < NR; k++) set_sample(k, 24'h000700 + 24'(k), 24'h000800 + 24'(k));
    clear_log();
    pulse(4'hF, 1'b0);
    tick(8);
    chk("f4_beats", log_chan.size(), 4);
    if (log_chan.size() == 4) begin
      chk("f4_first_chan", log_chan[0], 0);
      chk("f4_first_I", log_i[0], 24'h000700);
      chk("f4_last_chan", log_chan[3], 3);
      chk("f4_last", log_last[3], 1'b1);
    end

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) rx_enable = NR'($urandom_range(0, 15));
      for (int k = 0; k < NR; k++) set_sample(k, DW'($urandom), DW'($urandom));
      if ($urandom_range(0, 19) == 0) in_strobe = '1;
      else for (int k = 0; k < NR; k++) in_strobe[k] = ($urandom_range(0, 7) == 0);
      clear_overrun = ($urandom_range(0, 63) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    in_strobe     = '0;
    clear_overrun = 1'b0;
    bus.out_ready = 1'b1;
    tick(20);
    chk("rand_drained", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
